lc3_mem_arbiter: RTL

LC3_MEM_ARBITER -- requirements
Module: lc3_mem_arbiter

---
 rtl/lc3_mem_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/lc3_mem_arbiter.sv
`default_nettype none
// lc3_mem_arbiter: CPU/debug arbiter onto one shared single-cycle memory port.
// Macro LC3_ARB_ROUND_ROBIN_EN alternates simultaneous winners; otherwise debug always wins.
module lc3_mem_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_gnt,
  output logic        cpu_rvalid,
  output logic [15:0] cpu_rdata,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [15:0] dbg_addr,
  input  logic [15:0] dbg_wdata,
  output logic        dbg_gnt,
  output logic        dbg_rvalid,
  output logic [15:0] dbg_rdata,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  input  logic [15:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACC_CPU = 2'd1,
    ACC_DBG = 2'd2
  } state_t;

  state_t      state;
  logic        acc_we;
  logic [15:0] acc_addr;
  logic [15:0] acc_wdata;
  logic        cpu_win;
  logic        dbg_win;

`ifdef LC3_ARB_ROUND_ROBIN_EN
  logic last_winner_dbg;

  // On contention the requester that did not win last time goes first.
  always_comb begin
    cpu_win = 1'b0;
    dbg_win = 1'b0;
    if (state == IDLE) begin
      if (cpu_req && dbg_req) begin
        cpu_win = last_winner_dbg;
        dbg_win = !last_winner_dbg;
      end else begin
        cpu_win = cpu_req;
        dbg_win = dbg_req;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_winner_dbg <= 1'b1;
    end else if (cpu_win || dbg_win) begin
      last_winner_dbg <= dbg_win;
    end
  end
`else
  always_comb begin
    dbg_win = (state == IDLE) && dbg_req;
    cpu_win = (state == IDLE) && cpu_req && !dbg_req;
  end
`endif

  assign cpu_gnt = cpu_win;
  assign dbg_gnt = dbg_win;

  // Access fields are cleared on return to IDLE so the memory port idles at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      acc_we     <= 1'b0;
      acc_addr   <= 16'h0000;
      acc_wdata  <= 16'h0000;
      cpu_rvalid <= 1'b0;
      dbg_rvalid <= 1'b0;
      cpu_rdata  <= 16'h0000;
      dbg_rdata  <= 16'h0000;
    end else begin
      cpu_rvalid <= 1'b0;
      dbg_rvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (dbg_win) begin
            state     <= ACC_DBG;
            acc_we    <= dbg_we;
            acc_addr  <= dbg_addr;
            acc_wdata <= dbg_wdata;
          end else if (cpu_win) begin
            state     <= ACC_CPU;
            acc_we    <= cpu_we;
            acc_addr  <= cpu_addr;
            acc_wdata <= cpu_wdata;
          end
        end
        ACC_CPU: begin
          state     <= IDLE;
          acc_we    <= 1'b0;
          acc_addr  <= 16'h0000;
          acc_wdata <= 16'h0000;
          if (!acc_we) begin
            cpu_rvalid <= 1'b1;
            cpu_rdata  <= mem_rdata;
          end
        end
        ACC_DBG: begin
          state     <= IDLE;
          acc_we    <= 1'b0;
          acc_addr  <= 16'h0000;
          acc_wdata <= 16'h0000;
          if (!acc_we) begin
            dbg_rvalid <= 1'b1;
            dbg_rdata  <= mem_rdata;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_addr  = acc_addr;
  assign mem_wdata = acc_wdata;
  assign mem_we    = acc_we;
  assign busy      = (state != IDLE);

endmodule
`default_nettype wire
